fft_frame_sequencer: RTL

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

---
 rtl/fft_frame_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer between a bus slave and an FFT core. It buffers one frame of samples,
// streams them to the core, captures the magnitudes and serves them back over the bus.
module fft_frame_sequencer #(
  parameter int N_PT  = 128,
  parameter int IDX_W = 7,
  parameter int TMO_W = 12
) (
  input  logic             Bus2IP_Clk,
  input  logic             Bus2IP_Reset,
  input  logic [31:0]      Bus2IP_Data,
  input  logic             Bus2IP_WrReq,
  input  logic             Bus2IP_RdReq,
  output logic [31:0]      IP2Bus_Data,
  output logic             IP2Bus_WrAck,
  output logic             IP2Bus_RdAck,
  output logic             fft_start,
  output logic [15:0]      fft_xn_re,
  input  logic             fft_rfd,
  input  logic [IDX_W-1:0] fft_xn_index,
  input  logic             mag_valid,
  input  logic [31:0]      mag_data,
  output logic             frame_ready,
  output logic             overrun,
  output logic             fft_error
);

  // state   | meaning
  // FILL    | accepting sample writes into sample_buf
  // START   | one-cycle start pulse to the FFT core
  // LOAD    | core pulls samples by index until rfd falls
  // COMPUTE | capturing magnitude results into result_buf
  // READOUT | results readable over the bus
  typedef enum logic [2:0] {FILL, START, LOAD, COMPUTE, READOUT} state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [TMO_W-1:0] WD_LAST  = TMO_W'((2 ** TMO_W) - 2);
  localparam logic [TMO_W-1:0] WD_ONE   = TMO_W'(1);

  state_t           state, state_next;
  logic [IDX_W-1:0] wr_cnt, cap_cnt, rd_ptr;
  logic [TMO_W-1:0] wd_cnt;
  logic             rfd_seen;
  logic [15:0]      sample_buf [N_PT];
  logic [31:0]      result_buf [N_PT];

  logic wr_acc, rd_acc, fill_wr, cap_wr, rd_hit, wd_expire;
  logic unused_data_hi;

  assign unused_data_hi = ^Bus2IP_Data[31:16];

  always_comb begin
    wr_acc      = Bus2IP_WrReq & ~IP2Bus_WrAck;
    rd_acc      = Bus2IP_RdReq & ~IP2Bus_RdAck;
    // Expiring on the last count value means the full 2^TMO_W-1 cycles have elapsed.
    wd_expire   = ((state == LOAD) || (state == COMPUTE)) && (wd_cnt == WD_LAST);
    fill_wr     = (state == FILL) && wr_acc;
    cap_wr      = (state == COMPUTE) && mag_valid && !wd_expire;
    rd_hit      = (state == READOUT) && rd_acc;
    fft_start   = (state == START);
    frame_ready = (state == READOUT);
    fft_xn_re   = (state == LOAD) ? sample_buf[fft_xn_index] : 16'h0000;
    state_next  = state;
    case (state)
      FILL:    if (fill_wr && (wr_cnt == IDX_LAST)) state_next = START;
      START:   state_next = LOAD;
      LOAD: begin
        if (wd_expire)                 state_next = FILL;
        else if (rfd_seen && !fft_rfd) state_next = COMPUTE;
      end
      COMPUTE: begin
        if (wd_expire)                          state_next = FILL;
        else if (cap_wr && (cap_cnt == IDX_LAST)) state_next = READOUT;
      end
      READOUT: if (rd_hit && (rd_ptr == IDX_LAST)) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state        <= FILL;
      wr_cnt       <= '0;
      cap_cnt      <= '0;
      rd_ptr       <= '0;
      wd_cnt       <= '0;
      rfd_seen     <= 1'b0;
      IP2Bus_WrAck <= 1'b0;
      IP2Bus_RdAck <= 1'b0;
      IP2Bus_Data  <= '0;
      overrun      <= 1'b0;
      fft_error    <= 1'b0;
    end else begin
      state        <= state_next;
      IP2Bus_WrAck <= wr_acc;
      IP2Bus_RdAck <= rd_acc;
      IP2Bus_Data  <= rd_hit ? result_buf[rd_ptr] : 32'h0;
      rfd_seen     <= (state == LOAD) && (state_next == LOAD) && (rfd_seen || fft_rfd);
      if (wr_acc && (state != FILL)) overrun <= 1'b1;
      if (fill_wr) wr_cnt  <= (wr_cnt == IDX_LAST) ? '0 : wr_cnt + IDX_ONE;
      if (cap_wr)  cap_cnt <= (cap_cnt == IDX_LAST) ? '0 : cap_cnt + IDX_ONE;
      if (rd_hit)  rd_ptr  <= (rd_ptr == IDX_LAST) ? '0 : rd_ptr + IDX_ONE;
      if (state_next == START) begin
        wd_cnt <= '0;
      end else if (wd_expire) begin
        wd_cnt    <= '0;
        fft_error <= 1'b1;
        wr_cnt    <= '0;
        cap_cnt   <= '0;
        rd_ptr    <= '0;
      end else if ((state == LOAD) || (state == COMPUTE)) begin
        wd_cnt <= wd_cnt + WD_ONE;
      end
    end
  end

  // Buffers carry no reset; their contents are don't-care until rewritten.
  always_ff @(posedge Bus2IP_Clk) begin
    if (fill_wr && !Bus2IP_Reset) sample_buf[wr_cnt]  <= Bus2IP_Data[15:0];
    if (cap_wr && !Bus2IP_Reset)  result_buf[cap_cnt] <= mag_data;
  end

endmodule
